// File: rtl/joy_db15_scanner.sv
// DB15 UserIO scanner: clocks two 74HC165 chains and publishes 2x12 buttons.
// Define JOY_DB15_FILTER_EN to publish only after two identical raw scans.
module joy_db15_scanner #(
  parameter int CLK_DIV    = 8,
  parameter int IDLE_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        scan_done
);

  localparam int NBITS = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [7:0]  tick_cnt;
  logic        tick;
  logic [7:0]  idle_cnt;
  logic [7:0]  idle_nx;
  logic [4:0]  bit_cnt;
  logic [4:0]  bit_nx;
  logic        sample;
  logic        pub;
  logic [1:0]  sync;
  logic [23:0] shreg;
  logic [11:0] j1_q;
  logic [11:0] j2_q;

  assign tick      = (tick_cnt == 8'(CLK_DIV - 1));
  assign joystick1 = {4'h0, j1_q};
  assign joystick2 = {4'h0, j2_q};

  // Divider is held at zero in DONE so every scan starts phase-aligned.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tick_cnt <= 8'd0;
    end else if (tick || state == S_DONE) begin
      tick_cnt <= 8'd0;
    end else begin
      tick_cnt <= tick_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nx = state;
    idle_nx  = idle_cnt;
    bit_nx   = bit_cnt;
    sample   = 1'b0;
    pub      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tick) begin
          if (idle_cnt == 8'(IDLE_TICKS - 1)) begin
            state_nx = S_LOAD;
            idle_nx  = 8'd0;
          end else begin
            idle_nx = idle_cnt + 8'd1;
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          state_nx = S_LO;
          bit_nx   = 5'd0;
        end
      end
      S_LO: begin
        if (tick) begin
          sample   = 1'b1;
          state_nx = S_HI;
        end
      end
      S_HI: begin
        if (tick) begin
          if (bit_cnt == 5'(NBITS - 1)) begin
            state_nx = S_DONE;
          end else begin
            bit_nx   = bit_cnt + 5'd1;
            state_nx = S_LO;
          end
        end
      end
      S_DONE: begin
        pub      = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idle_cnt  <= 8'd0;
      bit_cnt   <= 5'd0;
      joy_clk   <= 1'b0;
      joy_load  <= 1'b1;
      scan_done <= 1'b0;
      sync      <= 2'b11;
      shreg     <= 24'd0;
    end else begin
      state     <= state_nx;
      idle_cnt  <= idle_nx;
      bit_cnt   <= bit_nx;
      joy_clk   <= (state_nx == S_HI);
      joy_load  <= (state_nx != S_LOAD);
      scan_done <= (state_nx == S_DONE);
      sync      <= {sync[0], joy_data};
      if (sample) begin
        shreg[bit_cnt] <= sync[1];
      end
    end
  end

`ifdef JOY_DB15_FILTER_EN
  logic [23:0] prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= 24'd0;
      j1_q <= 12'd0;
      j2_q <= 12'd0;
    end else if (pub) begin
      prev <= shreg;
      if (shreg == prev) begin
        j1_q <= ~shreg[11:0];
        j2_q <= ~shreg[23:12];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      j1_q <= 12'd0;
      j2_q <= 12'd0;
    end else if (pub) begin
      j1_q <= ~shreg[11:0];
      j2_q <= ~shreg[23:12];
    end
  end
`endif

endmodule

// File: tb/tb_joy_db15_scanner.sv
// Bench for joy_db15_scanner: 74HC165 chain model, directed scans,
// timing of load/clock, mid-scan reset and the optional filter.
module tb_joy_db15_scanner;

  localparam int DIV    = 4;
  localparam int IDLE   = 2;
  localparam int PERIOD = (IDLE + 1 + 48) * DIV + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        scan_done;

  logic [23:0] pattern;
  logic [23:0] chain;

  int checks   = 0;
  int failures = 0;
  int ovl      = 0;
  int s_cyc;
  int s_rise;
  int s_low;
  int s_first;

  logic [23:0] m_prev;
  logic [11:0] m_j1;
  logic [11:0] m_j2;

  always #5 clk = ~clk;

  joy_db15_scanner #(
    .CLK_DIV(DIV),
    .IDLE_TICKS(IDLE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .joy_data(joy_data),
    .joy_clk(joy_clk),
    .joy_load(joy_load),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .scan_done(scan_done)
  );

  // Two cascaded 165s as one 24-bit chain; bit 0 is on QH.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) chain <= pattern;
    else           chain <= {1'b1, chain[23:1]};
  end
  assign joy_data = chain[0];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [11:0] b1,
                                     input logic [11:0] b2);
    return ~{b2, b1};
  endfunction

  task automatic mdl_reset();
    m_prev = 24'd0;
    m_j1   = 12'd0;
    m_j2   = 12'd0;
  endtask

  task automatic mdl(input logic [23:0] raw);
`ifdef JOY_DB15_FILTER_EN
    if (raw == m_prev) begin
      m_j1 = ~raw[11:0];
      m_j2 = ~raw[23:12];
    end
    m_prev = raw;
`else
    m_j1 = ~raw[11:0];
    m_j2 = ~raw[23:12];
`endif
  endtask

  task automatic wait_scan();
    logic pc;
    s_cyc   = 0;
    s_rise  = 0;
    s_low   = 0;
    s_first = 0;
    pc      = joy_clk;
    while (s_cyc < 2000) begin
      @(posedge clk);
      @(negedge clk);
      s_cyc++;
      if (joy_clk && !pc) s_rise++;
      pc = joy_clk;
      if (!joy_load) begin
        s_low++;
        if (s_first == 0) s_first = s_cyc;
        if (joy_clk) ovl++;
      end
      if (scan_done) break;
    end
    if (s_cyc >= 2000) check("scan_timeout", 32'(s_cyc), 32'd0);
  endtask

  task automatic scan_and_check(input string tag,
                                input logic [11:0] b1,
                                input logic [11:0] b2);
    pattern = mk(b1, b2);
    wait_scan();
    mdl(pattern);
    @(negedge clk);
    check({tag, "_j1"}, 32'(joystick1), {20'd0, m_j1});
    check({tag, "_j2"}, 32'(joystick2), {20'd0, m_j2});
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    pattern = 24'hFFFFFF;
    mdl_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_load", 32'(joy_load), 32'd1);
      check("rst_clk", 32'(joy_clk), 32'd0);
      check("rst_j1", 32'(joystick1), 32'd0);
      check("rst_j2", 32'(joystick2), 32'd0);
      check("rst_done", 32'(scan_done), 32'd0);
    end
    reset_n = 1'b1;

    scan_and_check("idle", 12'h000, 12'h000);
    check("first_load", 32'(s_first), 32'd8);
    check("first_done", 32'(s_cyc), 32'd204);
    check("rises", 32'(s_rise), 32'd24);
    check("load_len", 32'(s_low), 32'd4);

    scan_and_check("ra1", 12'h011, 12'h000);
    check("period", 32'(s_cyc + 1), 32'(PERIOD));
    check("rises2", 32'(s_rise), 32'd24);
    scan_and_check("ra2", 12'h011, 12'h000);
    check("ra_pub", 32'(joystick1), 32'h0011);
    scan_and_check("mix", 12'hA5C, 12'h3F1);

    pattern = mk(12'h000, 12'h400);
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (joy_clk) break;
    end
    n = 0;
    s_rise = 1;
    while (n < 2000 && !(s_rise == 10 && !joy_clk)) begin
      logic pc;
      pc = joy_clk;
      @(negedge clk);
      n++;
      if (joy_clk && !pc) s_rise++;
    end
    check("bit10_reach", 32'(n < 2000), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    mdl_reset();
    check("mid_j1", 32'(joystick1), 32'd0);
    check("mid_j2", 32'(joystick2), 32'd0);
    check("mid_load", 32'(joy_load), 32'd1);
    check("mid_clk", 32'(joy_clk), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    scan_and_check("post1", 12'h000, 12'h400);
    check("post_done", 32'(s_cyc), 32'd204);
    scan_and_check("post2", 12'h000, 12'h400);
    check("post_pub", 32'(joystick2), 32'h0400);

`ifdef JOY_DB15_FILTER_EN
    scan_and_check("alt1", 12'h001, 12'h000);
    scan_and_check("alt2", 12'h002, 12'h000);
    scan_and_check("alt3", 12'h001, 12'h000);
    scan_and_check("alt4", 12'h002, 12'h000);
    check("alt_hold", 32'(joystick1), 32'h0000);
    scan_and_check("hold", 12'h002, 12'h000);
    check("hold_pub", 32'(joystick1), 32'h0002);
`endif

    check("overlap", 32'(ovl), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
